// File: rtl/mem_arb_lat.sv
// mem_arb_lat: round-robin arbiter in front of a single-ported 32-bit word memory.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous active-high reset (memory contents are kept)
//   req_val    per-port request valid
//   req_wait   per-port stall; 1 = requester must hold its request
//   req_type   per-port access type, 0 = read, 1 = write
//   req_addr   per-port byte address, port i in bits [32i+31:32i]
//   req_wdata  per-port write data, same packing
//   req_rdata  per-port read data, same packing; non-zero only for a completing read
//   busy       1 while a LATENCY>0 access is in flight
//   num_xfers  count of completed accesses (wraps)
//
// Words are indexed by addr[clog2(DEPTH)+1:2]; all other address bits are ignored.
// With LATENCY=0 an access completes in its grant cycle. Otherwise the granted
// port is latched as owner and completes LATENCY cycles later. The owner's
// request fields are sampled live at completion, not captured at grant.
module mem_arb_lat #(
  parameter int NPORTS  = 2,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORTS-1:0]      req_val,
  output logic [NPORTS-1:0]      req_wait,
  input  logic [NPORTS-1:0]      req_type,
  input  logic [32*NPORTS-1:0]   req_addr,
  input  logic [32*NPORTS-1:0]   req_wdata,
  output logic [32*NPORTS-1:0]   req_rdata,
  output logic                   busy,
  output logic [31:0]            num_xfers
);

  localparam int          AW = $clog2(DEPTH);
  localparam int          PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned NP = NPORTS;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     xfers_q, xfers_d;
  logic [31:0]     mem_q [DEPTH];

  logic            grant_vld;
  logic [PW-1:0]   grant;
  logic            done;
  logic [PW-1:0]   done_port;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic            sel_type;
  logic [AW-1:0]   widx;
  logic            we;
  logic            unused_addr_bits;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    if (int'(p) == NPORTS - 1) return '0;
    return p + 1'b1;
  endfunction

  // Cyclic scan starting at rr_ptr; the first requesting port wins.
  // Arbitration is suppressed while reset is held.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] idx_p;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    idx_p     = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NP) idx = idx - NP;
      idx_p = idx[PW-1:0];
      if (!rst && !grant_vld && req_val[idx_p]) begin
        grant_vld = 1'b1;
        grant     = idx_p;
      end
    end
  end

  // Next-state logic. Abandonment (owner drops req_val) takes priority over
  // completion, so an owner that drops val in its cnt=0 cycle writes nothing.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    xfers_d   = xfers_q;
    done      = 1'b0;
    done_port = owner_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          if (LATENCY == 0) begin
            done      = 1'b1;
            done_port = grant;
          end else begin
            state_d = BUSY;
            owner_d = grant;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (!req_val[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_port(owner_q);
        end else if (cnt_q == '0) begin
          done      = 1'b1;
          done_port = owner_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      rr_ptr_d = next_port(done_port);
      xfers_d  = xfers_q + 32'd1;
    end
  end

  // Datapath: the completing port's request is muxed straight from the inputs.
  always_comb begin
    sel_addr  = req_addr[32*int'(done_port) +: 32];
    sel_wdata = req_wdata[32*int'(done_port) +: 32];
    sel_type  = req_type[done_port];
    widx      = sel_addr[AW+1:2];
    we        = done && sel_type;
    req_wait  = req_val;
    req_rdata = '0;
    if (done) begin
      req_wait[done_port] = 1'b0;
      if (!sel_type) req_rdata[32*int'(done_port) +: 32] = mem_q[widx];
    end
  end

  assign unused_addr_bits = ^{sel_addr[31:AW+2], sel_addr[1:0]};

  // Memory array has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= sel_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      xfers_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      xfers_q  <= xfers_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign num_xfers = xfers_q;

endmodule

// File: doc/mem_arb_lat.md
MEM_ARB_LAT -- requirements
Module: mem_arb_lat

Interface
REQ-001 SHALL have parameter NPORTS, default 2, meaning number of requester ports (1..8).
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words (power of 2, >=4).
REQ-003 SHALL have parameter LATENCY, default 0, meaning cycles between grant and completion (0..15).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_val  input  NPORTS  per-port request valid.
REQ-007 SHALL have port req_wait  output  NPORTS  per-port stall; 1 = hold request.
REQ-008 SHALL have port req_type  input  NPORTS  per-port 0 = read, 1 = write.
REQ-009 SHALL have port req_addr  input  32*NPORTS  per-port byte address, port i in bits [32i+31:32i].
REQ-010 SHALL have port req_wdata  input  32*NPORTS  per-port write data, same packing.
REQ-011 SHALL have port req_rdata  output  32*NPORTS  per-port read data, same packing.
REQ-012 SHALL have port busy  output  1  1 while a LATENCY>0 access is in flight.
REQ-013 SHALL have port num_xfers  output  32  count of completed accesses.

Function
REQ-014 SHALL index words by addr[clog2(DEPTH)+1:2]; addr[1:0] and upper bits ignored (address wraps modulo DEPTH words).
REQ-015 SHALL implement FSM states IDLE and BUSY, plus registers owner, rr_ptr, cnt, num_xfers.
REQ-016 SHALL, in IDLE with any req_val set, grant the first requesting port at or after rr_ptr, scanning cyclically (NPORTS-1 wraps to 0).
REQ-017 SHALL, with LATENCY=0, complete the granted access in the grant cycle; FSM stays IDLE.
REQ-018 SHALL, with LATENCY>0, enter BUSY on the grant edge with owner latched and cnt=LATENCY-1; complete in the BUSY cycle where cnt=0; cnt decrements each BUSY cycle.
REQ-019 SHALL drive req_wait[i]=0 for the completing port in its completion cycle only; =1 for every other port with req_val=1; =0 for ports with req_val=0.
REQ-020 SHALL not re-arbitrate during BUSY; owner is fixed until completion or abandonment.
REQ-021 SHALL return the addressed word on req_rdata of the completing port combinationally in the completion cycle for reads; all other req_rdata slices SHALL be 0.
REQ-022 SHALL commit writes on the rising edge ending the completion cycle; a read completing in any later cycle SHALL see the new value.
REQ-023 SHALL, at completion, set rr_ptr to (owner+1) mod NPORTS, increment num_xfers (wrapping 2^32-1 -> 0), and return to IDLE (LATENCY>0).
REQ-024 SHALL treat owner req_val=0 in BUSY as abandonment: return to IDLE next edge, no write, no num_xfers increment, rr_ptr=(owner+1) mod NPORTS.
REQ-025 SHALL require requesters to hold type/addr/wdata stable while req_wait=1; behaviour otherwise is undefined.
REQ-026 SHALL assert busy exactly in BUSY state.
REQ-027 SHALL sample req_* of the owner (not latch them) at completion.

Reset
REQ-028 SHALL, on rst=1 at any time, asynchronously force IDLE, rr_ptr=0, owner=0, cnt=0, num_xfers=0, busy=0.
REQ-029 SHALL discard an in-flight access on reset mid-BUSY (no write, no count).
REQ-030 SHALL not clear the memory array on reset; contents persist across reset.
REQ-031 SHALL hold req_wait=0 for idle ports and req_rdata=0 while rst=1.

Verification
REQ-032 SHALL verify LATENCY=0, NPORTS=2: port0 write 0xdeadbeef @0x10, next cycle port0 read @0x10 -> wait=0 both cycles, rdata=0xdeadbeef, num_xfers=2.
REQ-033 SHALL verify LATENCY=0: both ports val same cycle after reset -> port0 served (wait0=0, wait1=1); next cycle port1 served; then port0 again (round-robin, rr_ptr wrap).
REQ-034 SHALL verify LATENCY=3: port1 read @0x8 -> wait1=1 for 3 cycles, busy=1 for 3 cycles, wait1=0 with data in 4th cycle; a port0 request arriving mid-BUSY waits until after.
REQ-035 SHALL verify LATENCY=2: owner drops val in BUSY before write completes -> IDLE next cycle, word unchanged on later read, num_xfers unchanged.
REQ-036 SHALL verify DEPTH=256: write 0x1234 @0x400 then read @0x0 -> 0x1234 (address wrap).
REQ-037 SHALL verify rst pulsed mid-BUSY on write -> busy=0 immediately, num_xfers=0, target word retains prior value, earlier written words persist.
